pe_array_acc: RTL

//  Parametrised 1-D PE array with an ifmap line buffer, a shared weight buffer, per-lane psum accumulation across passes,

---
 rtl/pe_array_acc_if.sv | 53 +++++
 rtl/pe_array_acc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_acc_if
// Purpose  : Operand-write, command and psum-drain bundle for pe_array_acc.
// Revision : 1.0  initial release
// ============================================================================
interface pe_array_acc_if #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int PSUM_W = 24,
    parameter int NPE    = 27,
    parameter int K      = 3,
    parameter int STRIDE = 1
) ();
    localparam int IB_D  = (NPE - 1) * STRIDE + K;
    localparam int IB_AW = $clog2(IB_D);
    localparam int WB_AW = $clog2(K);
    localparam int IDX_W = $clog2(NPE);
    localparam int FC_W  = PSUM_W + $clog2(NPE);

    logic              ib_wen;
    logic [IB_AW-1:0]  ib_waddr;
    logic [DATA_W-1:0] ib_wdata;
    logic              wb_wen;
    logic [WB_AW-1:0]  wb_waddr;
    logic [WGT_W-1:0]  wb_wdata;
    logic              buf_clear;
    logic              start;
    logic [1:0]        cmd;
    logic              first_pass;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready;
    logic [PSUM_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic [FC_W-1:0]   fc_out;
    logic              sat_flag;

    modport master (
        output ib_wen, ib_waddr, ib_wdata, wb_wen, wb_waddr, wb_wdata,
               buf_clear, start, cmd, first_pass, out_ready,
        input  busy, done, out_valid, out_data, out_idx, out_last, fc_out, sat_flag
    );

    modport slave (
        input  ib_wen, ib_waddr, ib_wdata, wb_wen, wb_waddr, wb_wdata,
               buf_clear, start, cmd, first_pass, out_ready,
        output busy, done, out_valid, out_data, out_idx, out_last, fc_out, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/pe_array_acc.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_acc
// Purpose  : 1-D PE array: ifmap/weight buffers, saturating per-lane psum
//            accumulation, handshaked psum drain and cross-lane reduction.
// Revision : 1.0  initial release
// ============================================================================
module pe_array_acc #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int PSUM_W = 24,
    parameter int NPE    = 27,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input wire            clk,
    input wire            rst,
    pe_array_acc_if.slave bus
);
    localparam int IB_D   = (NPE - 1) * STRIDE + K;
    localparam int IB_AW  = $clog2(IB_D);
    localparam int WB_AW  = $clog2(K);
    localparam int IDX_W  = $clog2(NPE);
    localparam int FC_W   = PSUM_W + $clog2(NPE);
    localparam int PROD_W = DATA_W + 1 + WGT_W;
    localparam int SUM_W  = PSUM_W + 1;

    localparam logic [1:0]              c_cmd_pass   = 2'd0;
    localparam logic [1:0]              c_cmd_drain  = 2'd1;
    localparam logic [1:0]              c_cmd_reduce = 2'd2;
    localparam logic [IDX_W-1:0]        c_last_idx   = IDX_W'(NPE - 1);
    localparam logic [IB_AW:0]          c_ib_depth   = (IB_AW + 1)'(IB_D);
    localparam logic [WB_AW:0]          c_wb_depth   = (WB_AW + 1)'(K);
    localparam logic signed [PSUM_W-1:0] c_psum_max  = {1'b0, {(PSUM_W - 1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] c_psum_min  = {1'b1, {(PSUM_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL    = 3'd1,
        S_ACC    = 3'd2,
        S_DRAIN  = 3'd3,
        S_REDUCE = 3'd4
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic                      w_done_nxt, w_xfer;
    logic                      r_fp, r_busy, r_done, r_sat;
    logic                      r_out_valid, r_out_last;
    logic [IDX_W-1:0]          r_out_idx, r_red_idx, w_out_idx_inc;
    logic signed [PSUM_W-1:0]  r_out_data;
    logic signed [FC_W-1:0]    r_fc_acc;
    logic [DATA_W-1:0]         r_ib [IB_D];
    logic signed [WGT_W-1:0]   r_wb [K];
    logic signed [PSUM_W-1:0]  w_psum [NPE];
    logic [NPE-1:0]            w_lane_sat;

    assign w_xfer        = r_out_valid & bus.out_ready;
    assign w_out_idx_inc = r_out_idx + IDX_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.cmd)
                        c_cmd_pass:   w_state_nxt = S_MUL;
                        c_cmd_drain:  w_state_nxt = S_DRAIN;
                        c_cmd_reduce: w_state_nxt = S_REDUCE;
                        default:      w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_MUL: w_state_nxt = S_ACC;
            S_ACC: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            S_DRAIN: begin
                if (w_xfer && (r_out_idx == c_last_idx)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_REDUCE: begin
                if (r_red_idx == c_last_idx) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_fp    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if ((r_state == S_IDLE) && (w_state_nxt != S_IDLE))
                r_fp <= bus.first_pass;
        end
    end

    // Operand buffers accept writes only while idle; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IB_D; i++) r_ib[i] <= '0;
            for (int i = 0; i < K; i++)    r_wb[i] <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.buf_clear) begin
                for (int i = 0; i < IB_D; i++) r_ib[i] <= '0;
                for (int i = 0; i < K; i++)    r_wb[i] <= '0;
            end else begin
                if (bus.ib_wen && ({1'b0, bus.ib_waddr} < c_ib_depth))
                    r_ib[bus.ib_waddr] <= bus.ib_wdata;
                if (bus.wb_wen && ({1'b0, bus.wb_waddr} < c_wb_depth))
                    r_wb[bus.wb_waddr] <= bus.wb_wdata;
            end
        end
    end

    for (genvar j = 0; j < NPE; j++) begin : g_lane
        logic signed [PROD_W-1:0] r_prod [K];
        logic signed [PSUM_W-1:0] r_psum;
        logic signed [SUM_W-1:0]  w_dot, w_base, w_sum;
        logic                     w_ovf;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int t = 0; t < K; t++) r_prod[t] <= '0;
            end else if (r_state == S_MUL) begin
                for (int t = 0; t < K; t++)
                    r_prod[t] <= PROD_W'($signed({1'b0, r_ib[j*STRIDE+t]})) * PROD_W'(r_wb[t]);
            end
        end

        // One guard bit above PSUM_W: overflow shows as the top two bits differing.
        always_comb begin
            w_dot = '0;
            for (int t = 0; t < K; t++) w_dot = w_dot + SUM_W'(r_prod[t]);
            w_base = r_fp ? '0 : SUM_W'(r_psum);
            w_sum  = w_base + w_dot;
            w_ovf  = w_sum[SUM_W-1] ^ w_sum[SUM_W-2];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_psum <= '0;
            else if (r_state == S_ACC)
                r_psum <= w_ovf ? (w_sum[SUM_W-1] ? c_psum_min : c_psum_max) : w_sum[PSUM_W-1:0];
        end

        assign w_psum[j]     = r_psum;
        assign w_lane_sat[j] = w_ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sat <= 1'b0;
        else if (r_state == S_ACC)
            r_sat <= (r_fp ? 1'b0 : r_sat) | (|w_lane_sat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_DRAIN)) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= '0;
            r_out_data  <= w_psum[0];
            r_out_last  <= (c_last_idx == '0);
        end else if ((r_state == S_DRAIN) && w_xfer) begin
            if (r_out_idx == c_last_idx) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                r_out_idx  <= w_out_idx_inc;
                r_out_data <= w_psum[w_out_idx_inc];
                r_out_last <= (w_out_idx_inc == c_last_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_red_idx <= '0;
            r_fc_acc  <= '0;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_REDUCE)) begin
            r_red_idx <= '0;
        end else if (r_state == S_REDUCE) begin
            r_fc_acc <= ((r_fp && (r_red_idx == '0)) ? '0 : r_fc_acc) + FC_W'(w_psum[r_red_idx]);
            if (r_red_idx != c_last_idx)
                r_red_idx <= r_red_idx + IDX_W'(1);
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;
    assign bus.fc_out    = r_fc_acc;
    assign bus.sat_flag  = r_sat;
endmodule
`default_nettype wire
